// File: rtl/ibex_pkg.sv
// Shared types and constants for the CHERI capability access sequencer.
package ibex_pkg;

    localparam int unsigned CheriExcWidth = 5;

    // Bit positions within the checker exception vector.
    localparam int unsigned CheriExcTagBit    = 0;
    localparam int unsigned CheriExcSealBit   = 1;
    localparam int unsigned CheriExcPermBit   = 2;
    localparam int unsigned CheriExcLengthBit = 3;
    localparam int unsigned CheriExcAlignBit  = 4;

    localparam int unsigned CapMemBytes   = 8;
    localparam logic [1:0]  DATA_TYPE_CAP = 2'b11;

    typedef enum logic [2:0] {
        CapSeqIdle,
        CapSeqLoReq,
        CapSeqLoResp,
        CapSeqHiReq,
        CapSeqHiResp,
        CapSeqDone
    } cap_seq_state_e;

endpackage

// File: rtl/ibex_cheri_cap_access_seq.sv
// Sequences LSU accesses onto the 32-bit data bus; capability accesses become two word beats,
// with the checker's exception vector folded into the result.
module ibex_cheri_cap_access_seq
    import ibex_pkg::*;
#(
    parameter bit          CheckCapAlign = 1'b1,
    parameter int unsigned CheriExcW     = CheriExcWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic                 cap_i,
    input  logic [1:0]           type_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          addr_i,
    input  logic [63:0]          wdata_i,
    input  logic                 wtag_i,

    output logic                 done_o,
    output logic [63:0]          rdata_o,
    output logic                 rtag_o,
    output logic                 err_o,
    output logic                 misalign_o,
    output logic [CheriExcW-1:0] cheri_exc_o,

    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    input  logic [31:0]          data_rdata_i,
    input  logic                 data_tag_i,
    output logic [31:0]          data_addr_o,
    output logic                 data_we_o,
    output logic [1:0]           data_type_o,
    output logic [3:0]           data_be_o,
    output logic                 data_cap_o,
    output logic [31:0]          data_wdata_o,
    output logic                 data_wtag_o,

    input  logic [CheriExcW-1:0] chk_exc_i
);

    localparam logic [31:0] CapAlignMask = 32'(CapMemBytes - 1);
    localparam logic [31:0] CapHiOffset  = 32'(CapMemBytes / 2);

    cap_seq_state_e r_state, w_state_d;

    logic                 r_we, r_cap, r_wtag;
    logic [1:0]           r_type;
    logic [3:0]           r_be;
    logic [31:0]          r_addr;
    logic [63:0]          r_wdata;
    logic [63:0]          r_rdata;
    logic                 r_tag_lo, r_tag_hi;
    logic                 r_err, r_misalign;
    logic                 r_first;
    logic [CheriExcW-1:0] r_exc;

    logic                 w_accept;
    logic                 w_misalign_in;
    logic                 w_is_hi;
    logic                 w_in_resp;
    logic                 w_fault;
    logic [CheriExcW-1:0] w_exc_now;
    logic [CheriExcW-1:0] w_exc_sum;

    assign w_accept      = (r_state == CapSeqIdle) && req_i;
    assign w_misalign_in = CheckCapAlign && cap_i && ((addr_i & CapAlignMask) != 32'd0);
    assign w_is_hi       = (r_state == CapSeqHiReq);
    assign w_in_resp     = (r_state == CapSeqLoResp) || (r_state == CapSeqHiResp);
    // The checker vector is only meaningful in the cycle right after a grant.
    assign w_exc_now     = r_first ? chk_exc_i : '0;
    assign w_exc_sum     = r_exc | w_exc_now;
    assign w_fault       = r_err | r_misalign | (|r_exc);

    always_comb begin
        w_state_d    = r_state;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        data_req_o   = 1'b0;
        data_addr_o  = 32'd0;
        data_we_o    = 1'b0;
        data_type_o  = 2'b00;
        data_be_o    = 4'h0;
        data_cap_o   = 1'b0;
        data_wdata_o = 32'd0;
        data_wtag_o  = 1'b0;

        case (r_state)
            CapSeqIdle: begin
                ready_o = 1'b1;
                if (req_i) begin
                    w_state_d = w_misalign_in ? CapSeqDone : CapSeqLoReq;
                end
            end
            CapSeqLoReq: begin
                data_req_o = 1'b1;
                if (data_gnt_i) w_state_d = CapSeqLoResp;
            end
            CapSeqLoResp: begin
                if (data_rvalid_i) begin
                    w_state_d = (r_cap && !data_err_i && (w_exc_sum == '0)) ? CapSeqHiReq
                                                                             : CapSeqDone;
                end
            end
            CapSeqHiReq: begin
                data_req_o = 1'b1;
                if (data_gnt_i) w_state_d = CapSeqHiResp;
            end
            CapSeqHiResp: begin
                if (data_rvalid_i) w_state_d = CapSeqDone;
            end
            CapSeqDone: begin
                done_o    = 1'b1;
                w_state_d = CapSeqIdle;
            end
            default: w_state_d = CapSeqIdle;
        endcase

        if (data_req_o) begin
            data_addr_o  = w_is_hi ? (r_addr + CapHiOffset) : r_addr;
            data_we_o    = r_we;
            data_wdata_o = w_is_hi ? r_wdata[63:32] : r_wdata[31:0];
            if (r_cap) begin
                // Low beat carries the cap type so the checker bounds-checks all 8 bytes.
                data_type_o = w_is_hi ? 2'b00 : DATA_TYPE_CAP;
                data_be_o   = 4'hF;
                data_cap_o  = 1'b1;
                data_wtag_o = r_wtag;
            end else begin
                data_type_o = r_type;
                data_be_o   = r_be;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= CapSeqIdle;
            r_we       <= 1'b0;
            r_cap      <= 1'b0;
            r_wtag     <= 1'b0;
            r_type     <= 2'b00;
            r_be       <= 4'h0;
            r_addr     <= 32'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_tag_lo   <= 1'b0;
            r_tag_hi   <= 1'b0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_first    <= 1'b0;
            r_exc      <= '0;
        end else begin
            r_state <= w_state_d;
            r_first <= data_req_o & data_gnt_i;
            if (w_accept) begin
                r_we       <= we_i;
                r_cap      <= cap_i;
                r_wtag     <= wtag_i;
                r_type     <= type_i;
                r_be       <= be_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
                r_rdata    <= 64'd0;
                r_tag_lo   <= 1'b0;
                r_tag_hi   <= 1'b0;
                r_err      <= 1'b0;
                r_misalign <= w_misalign_in;
                r_exc      <= '0;
            end else begin
                r_exc <= w_exc_sum;
                if (w_in_resp && data_rvalid_i) begin
                    r_err <= r_err | data_err_i;
                    if (!r_we) begin
                        if (r_state == CapSeqHiResp) begin
                            r_rdata[63:32] <= data_rdata_i;
                            r_tag_hi       <= data_tag_i;
                        end else begin
                            r_rdata[31:0]  <= data_rdata_i;
                            r_tag_lo       <= data_tag_i;
                        end
                    end
                end
            end
        end
    end

    assign rdata_o     = w_fault ? 64'd0 : r_rdata;
    assign rtag_o      = r_cap & r_tag_lo & r_tag_hi & ~w_fault;
    assign err_o       = r_err;
    assign misalign_o  = r_misalign;
    assign cheri_exc_o = r_exc;

endmodule
